alu_arbiter: RTL

- Round-robin arbiter and sequencer that shares one 4-bit combinational ALU (operands a/b, 3-bit select s, outputs r/c/v) among NREQ requesters.
- Each requester issues operations over a valid/ready request channel and collects the result over a valid/ready response channel.
- The block registers operands, drives the ALU, captures r/c/v and routes the result to the owning requester.
- Sits between the ALU instance and its client logic.

---
 rtl/alu_arbiter_if.sv | 32 +++
 rtl/alu_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// ============================================================================
// alu_arbiter_if : request/response bus between requesters and alu_arbiter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic [3*NREQ-1:0] req_s;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [3:0]        rsp_r;
  logic              rsp_c;
  logic              rsp_v;

  modport master (
    output req_valid, req_a, req_b, req_s, rsp_ready,
    input  req_ready, rsp_valid, rsp_r, rsp_c, rsp_v
  );

  modport slave (
    input  req_valid, req_a, req_b, req_s, rsp_ready,
    output req_ready, rsp_valid, rsp_r, rsp_c, rsp_v
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter : round-robin sharing of one 4-bit ALU among NREQ requesters.
// Optional per-requester grant counters: define ALU_ARB_STATS_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int NREQ = 2
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  output logic [2:0]    alu_s,
  input  logic [3:0]    alu_r,
  input  logic          alu_c,
  input  logic          alu_v,
  output logic          busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [8*NREQ-1:0] grant_cnt
`endif
);

  localparam int            IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [3:0]    op_a_q, op_a_d;
  logic [3:0]    op_b_q, op_b_d;
  logic [2:0]    op_s_q, op_s_d;
  logic [3:0]    rsp_r_q, rsp_r_d;
  logic          rsp_c_q, rsp_c_d;
  logic          rsp_v_q, rsp_v_d;

  logic [3:0]      w_req_a [NREQ];
  logic [3:0]      w_req_b [NREQ];
  logic [2:0]      w_req_s [NREQ];
  logic            w_gnt_found;
  logic [IW-1:0]   w_gnt_idx;
  int              w_best;
  logic            w_accept;
  logic [NREQ-1:0] w_req_ready;
  logic [NREQ-1:0] w_rsp_valid;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_req_a[gi] = bus.req_a[4*gi +: 4];
      assign w_req_b[gi] = bus.req_b[4*gi +: 4];
      assign w_req_s[gi] = bus.req_s[3*gi +: 3];
    end
  endgenerate

  // Winner is the valid requester closest after last_grant in circular order.
  always_comb begin : p_grant
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_best      = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i] &&
          (((i + NREQ - 1 - int'(last_grant_q)) % NREQ) < w_best)) begin
        w_best      = (i + NREQ - 1 - int'(last_grant_q)) % NREQ;
        w_gnt_found = 1'b1;
        w_gnt_idx   = IW'(i);
      end
    end
  end

  assign w_accept = (state_q == S_IDLE) && w_gnt_found;

  always_comb begin : p_fsm
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_s_d       = op_s_q;
    rsp_r_d      = rsp_r_q;
    rsp_c_d      = rsp_c_q;
    rsp_v_d      = rsp_v_q;
    w_req_ready  = '0;
    w_rsp_valid  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (w_gnt_found) begin
          w_req_ready[w_gnt_idx] = 1'b1;
          op_a_d       = w_req_a[w_gnt_idx];
          op_b_d       = w_req_b[w_gnt_idx];
          op_s_d       = w_req_s[w_gnt_idx];
          owner_d      = w_gnt_idx;
          last_grant_d = w_gnt_idx;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_r_d = alu_r;
        rsp_c_d = alu_c;
        rsp_v_d = alu_v;
        state_d = S_RESP;
      end
      S_RESP: begin
        w_rsp_valid[owner_q] = 1'b1;
        if (bus.rsp_ready[owner_q]) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin : p_regs
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= LAST_INIT;
      owner_q      <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_s_q       <= '0;
      rsp_r_q      <= '0;
      rsp_c_q      <= 1'b0;
      rsp_v_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_s_q       <= op_s_d;
      rsp_r_q      <= rsp_r_d;
      rsp_c_q      <= rsp_c_d;
      rsp_v_q      <= rsp_v_d;
    end
  end

  // Operand registers only change on acceptance, so the ALU inputs hold outside EXEC.
  assign alu_a         = op_a_q;
  assign alu_b         = op_b_q;
  assign alu_s         = op_s_q;
  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_r     = rsp_r_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_v     = rsp_v_q;
  assign busy          = (state_q != S_IDLE);

`ifdef ALU_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
      logic [7:0] cnt_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else if (w_accept && (w_gnt_idx == IW'(gi))) begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
      assign grant_cnt[8*gi +: 8] = cnt_q;
    end
  endgenerate
`endif

endmodule

`default_nettype wire
